// File: rtl/reg_writeback_buffer.sv
// reg_writeback_buffer: FIFO of pending register-file writes with youngest-match bypass
module reg_writeback_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_rd,
  input  logic [XLEN-1:0]          in_data,
  input  logic                     rf_hold,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [XLEN-1:0]          rf_wdata,
  input  logic [4:0]               byp_rs1,
  input  logic [4:0]               byp_rs2,
  output logic                     byp_hit1,
  output logic                     byp_hit2,
  output logic [XLEN-1:0]          byp_data1,
  output logic [XLEN-1:0]          byp_data2,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [4:0]        rd_q   [DEPTH];
  logic [XLEN-1:0]   data_q [DEPTH];
  logic              push, pop;
  logic [AW-1:0]     idx;
  assign in_ready = cnt_q < FULL;
  assign push     = in_valid && in_ready && in_rd != 5'd0;
  assign pop      = cnt_q != '0 && !rf_hold;
  assign rf_we    = pop;
  assign rf_waddr = pop ? rd_q[rd_ptr_q] : 5'd0;
  assign rf_wdata = pop ? data_q[rd_ptr_q] : '0;
  assign count    = cnt_q;
  // next-state for pointers and occupancy; x0 requests handshake but never enqueue
  always_comb begin
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  // pointer and occupancy registers; reset discards all pending entries
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
  // entry storage; validity comes solely from the occupancy window
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wr_ptr_q]   <= in_rd;
      data_q[wr_ptr_q] <= in_data;
    end
  end
  // bypass scans oldest to youngest so the youngest match wins
  always_comb begin
    byp_hit1  = 1'b0;
    byp_hit2  = 1'b0;
    byp_data1 = '0;
    byp_data2 = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + AW'(k);
      if (k < int'(cnt_q) && byp_rs1 != 5'd0 && rd_q[idx] == byp_rs1) begin
        byp_hit1  = 1'b1;
        byp_data1 = data_q[idx];
      end
      if (k < int'(cnt_q) && byp_rs2 != 5'd0 && rd_q[idx] == byp_rs2) begin
        byp_hit2  = 1'b1;
        byp_data2 = data_q[idx];
      end
    end
  end
endmodule

// File: tb/tb_reg_writeback_buffer.sv
// tb_reg_writeback_buffer: table-driven and sequence checks of the writeback buffer
module tb_reg_writeback_buffer;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, rf_hold, rf_we, byp_hit1, byp_hit2;
  logic [4:0]  in_rd, rf_waddr, byp_rs1, byp_rs2;
  logic [31:0] in_data, rf_wdata, byp_data1, byp_data2;
  logic [2:0]  count;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic v; logic [4:0] rd; logic [31:0] d; logic hold; logic [4:0] rs1, rs2;
    logic rdy, we; logic [4:0] wa; logic [31:0] wd;
    logic h1; logic [31:0] d1; logic h2; logic [31:0] d2; logic [2:0] cnt;
  } vec_t;
  vec_t tbl [22];
  logic [4:0]  q_rd [$];
  logic [31:0] q_d  [$];
  reg_writeback_buffer #(.XLEN(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_data(in_data), .rf_hold(rf_hold), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .byp_rs1(byp_rs1), .byp_rs2(byp_rs2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data1(byp_data1),
    .byp_data2(byp_data2), .count(count)
  );
  always #5 clk = ~clk;
  function automatic vec_t mkv(logic v, logic [4:0] rd, logic [31:0] d, logic hold,
                               logic [4:0] rs1, logic [4:0] rs2, logic rdy, logic we,
                               logic [4:0] wa, logic [31:0] wd, logic h1, logic [31:0] d1,
                               logic h2, logic [31:0] d2, logic [2:0] cnt);
    vec_t r;
    r.v = v; r.rd = rd; r.d = d; r.hold = hold; r.rs1 = rs1; r.rs2 = rs2;
    r.rdy = rdy; r.we = we; r.wa = wa; r.wd = wd;
    r.h1 = h1; r.d1 = d1; r.h2 = h2; r.d2 = d2; r.cnt = cnt;
    return r;
  endfunction
  task automatic chk(string name, logic [107:0] got, logic [107:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask
  function automatic logic [107:0] outs();
    return {in_ready, rf_we, rf_waddr, rf_wdata, byp_hit1, byp_data1, byp_hit2, byp_data2, count};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    //            v rd    data          hold rs1 rs2  rdy we wa    wd           h1 d1           h2 d2          cnt
    tbl[0]  = mkv(0, 0,  32'h0,         0,   0,  0,   1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0,       0);
    tbl[1]  = mkv(1, 5,  32'hAA,        0,   5,  0,   1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0,       0);
    tbl[2]  = mkv(0, 0,  32'h0,         0,   5,  0,   1, 1, 5,  32'hAA,       1, 32'hAA,       0, 32'h0,       1);
    tbl[3]  = mkv(0, 0,  32'h0,         0,   5,  0,   1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0,       0);
    tbl[4]  = mkv(1, 0,  32'hFFFF_FFFF, 0,   0,  0,   1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0,       0);
    tbl[5]  = mkv(0, 0,  32'h0,         0,   0,  0,   1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0,       0);
    tbl[6]  = mkv(1, 1,  32'h101,       1,   0,  0,   1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0,       0);
    tbl[7]  = mkv(1, 2,  32'h102,       1,   1,  0,   1, 0, 0,  32'h0,        1, 32'h101,      0, 32'h0,       1);
    tbl[8]  = mkv(1, 3,  32'h103,       1,   2,  1,   1, 0, 0,  32'h0,        1, 32'h102,      1, 32'h101,     2);
    tbl[9]  = mkv(1, 4,  32'h104,       1,   0,  0,   1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0,       3);
    tbl[10] = mkv(1, 9,  32'h109,       1,   4,  0,   0, 0, 0,  32'h0,        1, 32'h104,      0, 32'h0,       4);
    tbl[11] = mkv(0, 0,  32'h0,         0,   9,  0,   0, 1, 1,  32'h101,      0, 32'h0,        0, 32'h0,       4);
    tbl[12] = mkv(0, 0,  32'h0,         0,   0,  0,   1, 1, 2,  32'h102,      0, 32'h0,        0, 32'h0,       3);
    tbl[13] = mkv(0, 0,  32'h0,         0,   0,  0,   1, 1, 3,  32'h103,      0, 32'h0,        0, 32'h0,       2);
    tbl[14] = mkv(0, 0,  32'h0,         0,   1,  4,   1, 1, 4,  32'h104,      0, 32'h0,        1, 32'h104,     1);
    tbl[15] = mkv(0, 0,  32'h0,         0,   0,  0,   1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0,       0);
    tbl[16] = mkv(1, 7,  32'h11,        1,   7,  8,   1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0,       0);
    tbl[17] = mkv(1, 7,  32'h22,        1,   7,  8,   1, 0, 0,  32'h0,        1, 32'h11,       0, 32'h0,       1);
    tbl[18] = mkv(0, 0,  32'h0,         1,   7,  8,   1, 0, 0,  32'h0,        1, 32'h22,       0, 32'h0,       2);
    tbl[19] = mkv(0, 0,  32'h0,         0,   7,  8,   1, 1, 7,  32'h11,       1, 32'h22,       0, 32'h0,       2);
    tbl[20] = mkv(0, 0,  32'h0,         0,   7,  8,   1, 1, 7,  32'h22,       1, 32'h22,       0, 32'h0,       1);
    tbl[21] = mkv(0, 0,  32'h0,         0,   7,  8,   1, 0, 0,  32'h0,        0, 32'h0,        0, 32'h0,       0);
    reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0; rf_hold = 1'b0; byp_rs1 = '0; byp_rs2 = '0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 22; i++) begin
      in_valid = tbl[i].v; in_rd = tbl[i].rd; in_data = tbl[i].d; rf_hold = tbl[i].hold;
      byp_rs1 = tbl[i].rs1; byp_rs2 = tbl[i].rs2;
      @(negedge clk);
      chk($sformatf("row%0d", i), outs(),
          {tbl[i].rdy, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].h1, tbl[i].d1, tbl[i].h2, tbl[i].d2, tbl[i].cnt});
      tick();
    end
    in_valid = 1'b0; byp_rs1 = '0; byp_rs2 = '0;
    rf_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_rd = 5'(10 + i); in_data = 32'(32'h200 + 10 + i);
      q_rd.push_back(in_rd); q_d.push_back(in_data);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("wrap_fill_count", 108'(count), 108'(3));
    tick();
    rf_hold = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_rd = 5'(13 + i); in_data = 32'(32'h200 + 13 + i);
      @(negedge clk);
      chk($sformatf("wrap_cnt%0d", i), 108'(count), 108'(3));
      chk($sformatf("wrap_out%0d", i), 108'({rf_we, rf_waddr, rf_wdata}), 108'({1'b1, q_rd[0], q_d[0]}));
      void'(q_rd.pop_front()); void'(q_d.pop_front());
      q_rd.push_back(in_rd); q_d.push_back(in_data);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("drain_out%0d", i), 108'({rf_we, rf_waddr, rf_wdata}), 108'({1'b1, q_rd[0], q_d[0]}));
      void'(q_rd.pop_front()); void'(q_d.pop_front());
      tick();
    end
    @(negedge clk);
    chk("drain_empty", 108'({rf_we, count}), 108'(0));
    rf_hold = 1'b1;
    in_valid = 1'b1; in_rd = 5'd3; in_data = 32'h33;
    tick();
    in_rd = 5'd6; in_data = 32'h66;
    tick();
    in_valid = 1'b0; byp_rs1 = 5'd3; byp_rs2 = 5'd6;
    @(negedge clk);
    chk("prereset", 108'({count, byp_hit1, byp_data1, byp_hit2, byp_data2}),
        108'({3'd2, 1'b1, 32'h33, 1'b1, 32'h66}));
    reset = 1'b1; rf_hold = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("postreset", outs(), {1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 3'd0});
    tick();
    @(negedge clk);
    chk("postreset2", 108'({rf_we, count}), 108'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_writeback_buffer.md
REG_WRITEBACK_BUFFER -- requirements
Module: reg_writeback_buffer

Interface
REQ-001 Parameter XLEN, default 32, data width of register-file write data.
REQ-002 Parameter DEPTH, default 4, number of buffer entries (power of two, 2..16).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  producer presents a writeback request.
REQ-006 in_ready  output  1  buffer can accept a request this cycle.
REQ-007 in_rd  input  5  destination register index.
REQ-008 in_data  input  XLEN  destination write data.
REQ-009 rf_hold  input  1  register-file write port is claimed by another writer this cycle.
REQ-010 rf_we  output  1  write enable to register-file write port.
REQ-011 rf_waddr  output  5  write address to register-file write port.
REQ-012 rf_wdata  output  XLEN  write data to register-file write port.
REQ-013 byp_rs1, byp_rs2  input  5 each  source indices to check against pending writes.
REQ-014 byp_hit1, byp_hit2  output  1 each  a pending write exists for the matching source.
REQ-015 byp_data1, byp_data2  output  XLEN each  data of the youngest matching pending write.
REQ-016 count  output  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-017 Buffer SHALL be a FIFO of {rd, data} entries with read pointer, write pointer and occupancy counter; pointers wrap modulo DEPTH.
REQ-018 in_ready SHALL equal (count < DEPTH); no pass-through when full, even if an entry drains in the same cycle.
REQ-019 A request SHALL be accepted on a rising edge where in_valid and in_ready are both high.
REQ-020 An accepted request with in_rd = 0 SHALL complete the handshake but SHALL NOT be enqueued (x0 writes dropped).
REQ-021 rf_we SHALL equal (count != 0) and not rf_hold; rf_waddr/rf_wdata SHALL present the head entry combinationally.
REQ-022 Head entry SHALL be dequeued on each rising edge where rf_we is high; at most one dequeue per cycle.
REQ-023 Latency: a request accepted at edge N into an empty buffer SHALL appear on rf_we during cycle N+1 (absent rf_hold).
REQ-024 rf_hold high SHALL freeze the head entry and read pointer; enqueue continues while not full.
REQ-025 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-026 Entries SHALL drain in acceptance order; duplicate rd entries SHALL both be written, older first.
REQ-027 byp_hitN SHALL be high when any occupied entry has rd = byp_rsN and byp_rsN != 0; byp_dataN SHALL be the data of the youngest such entry.
REQ-028 Bypass SHALL be purely combinational over stored entries only; a request being accepted in the same cycle SHALL NOT hit.
REQ-029 When byp_hitN is low, byp_dataN SHALL be 0.
REQ-030 rf_waddr and rf_wdata SHALL be 0 whenever rf_we is low.

Reset
REQ-031 While reset is high at a rising edge, pointers and count SHALL clear to 0 and all stored entries SHALL be treated as invalid; in_valid is ignored.
REQ-032 After reset: in_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0, byp_hit1/2=0, byp_data1/2=0, count=0.
REQ-033 Reset asserted mid-drain SHALL discard all pending entries; no rf_we pulse SHALL occur in the cycle following the reset edge.

Verification
REQ-034 Push (rd=5, data=0x0000_00AA) into empty buffer, rf_hold=0 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xAA; following cycle count=0, rf_we=0.
REQ-035 rf_hold=1, push 4 requests rd=1..4 -> count=4, in_ready=0; fifth in_valid not accepted; release rf_hold -> writes rd 1,2,3,4 on four consecutive cycles.
REQ-036 Push rd=0 data=0xFFFF_FFFF -> handshake completes, count stays 0, rf_we never asserted, byp_rs1=0 gives byp_hit1=0.
REQ-037 rf_hold=1, push (rd=7,0x11) then (rd=7,0x22), byp_rs1=7, byp_rs2=8 -> byp_hit1=1, byp_data1=0x22, byp_hit2=0, byp_data2=0; release -> 0x11 written before 0x22.
REQ-038 Buffer holding 3 entries, simultaneous push and drain for 8 cycles -> count stays 3, pointers wrap, output order matches input order.
REQ-039 Buffer holding 2 entries, assert reset for one edge -> count=0, in_ready=1, rf_we=0 next cycle, byp_hit1/2=0.
